// File: rtl/mm_operand_feeder.sv
// Operand feeder for the sum-stationary array: buffers full A and B matrices
// from row writes, then streams one A column and one B row per accepted transfer.
module mm_operand_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned N          = 4,
  parameter int unsigned IDX_BITS   = $clog2(N + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load_valid_i,
  input  logic                  load_is_b_i,
  input  logic [DATA_WIDTH-1:0] load_row_i [N-1:0],
  output logic                  load_ready_o,
  output logic                  a_input_valid_o,
  output logic                  b_input_valid_o,
  output logic [DATA_WIDTH-1:0] a_data_o [N-1:0],
  output logic [DATA_WIDTH-1:0] b_data_o [N-1:0],
  output logic                  last_o,
  input  logic                  input_ready_i,
  output logic                  busy_o
);

  localparam int unsigned AW = (N > 1) ? $clog2(N) : 1;

  localparam logic [0:0] ST_LOAD   = 1'b0;
  localparam logic [0:0] ST_STREAM = 1'b1;

  localparam logic [IDX_BITS-1:0] CNT_FULL = IDX_BITS'(N);
  localparam logic [IDX_BITS-1:0] K_LAST   = IDX_BITS'(N - 1);

  logic [0:0]          state_q, state_d;
  logic [IDX_BITS-1:0] a_cnt_q, a_cnt_d;
  logic [IDX_BITS-1:0] b_cnt_q, b_cnt_d;
  logic [IDX_BITS-1:0] k_q, k_d;

  logic [DATA_WIDTH-1:0] a_mem_q [N-1:0][N-1:0];
  logic [DATA_WIDTH-1:0] b_mem_q [N-1:0][N-1:0];

  logic          a_wr_en, b_wr_en;
  logic [AW-1:0] a_wr_idx, b_wr_idx, k_idx;

  assign a_wr_idx = AW'(a_cnt_q);
  assign b_wr_idx = AW'(b_cnt_q);
  assign k_idx    = AW'(k_q);

  // State and counter registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_LOAD;
      a_cnt_q <= '0;
      b_cnt_q <= '0;
      k_q     <= '0;
    end else begin
      state_q <= state_d;
      a_cnt_q <= a_cnt_d;
      b_cnt_q <= b_cnt_d;
      k_q     <= k_d;
    end
  end

  // Operand buffers are not reset; counters gate what is considered loaded
  always_ff @(posedge clk) begin
    if (a_wr_en) a_mem_q[a_wr_idx] <= load_row_i;
    if (b_wr_en) b_mem_q[b_wr_idx] <= load_row_i;
  end

  // Next-state and output logic
  always_comb begin
    state_d         = state_q;
    a_cnt_d         = a_cnt_q;
    b_cnt_d         = b_cnt_q;
    k_d             = k_q;
    a_wr_en         = 1'b0;
    b_wr_en         = 1'b0;
    load_ready_o    = 1'b0;
    a_input_valid_o = 1'b0;
    b_input_valid_o = 1'b0;
    last_o          = 1'b0;
    busy_o          = 1'b0;
    for (int i = 0; i < N; i++) begin
      a_data_o[i] = '0;
      b_data_o[i] = '0;
    end

    if (reset) begin
      state_d = ST_LOAD;
      a_cnt_d = '0;
      b_cnt_d = '0;
      k_d     = '0;
    end else begin
      case (state_q)
        ST_LOAD: begin
          load_ready_o = load_is_b_i ? (b_cnt_q < CNT_FULL) : (a_cnt_q < CNT_FULL);
          if (load_valid_i && load_ready_o) begin
            if (load_is_b_i) begin
              b_wr_en = 1'b1;
              b_cnt_d = b_cnt_q + IDX_BITS'(1);
            end else begin
              a_wr_en = 1'b1;
              a_cnt_d = a_cnt_q + IDX_BITS'(1);
            end
          end
          if (a_cnt_d == CNT_FULL && b_cnt_d == CNT_FULL) state_d = ST_STREAM;
        end
        ST_STREAM: begin
          // Valid is unconditional so the array's ready cannot loop back into it
          a_input_valid_o = 1'b1;
          b_input_valid_o = 1'b1;
          busy_o          = 1'b1;
          last_o          = (k_q == K_LAST);
          for (int i = 0; i < N; i++) begin
            a_data_o[i] = a_mem_q[i][k_idx];
            b_data_o[i] = b_mem_q[k_idx][i];
          end
          if (input_ready_i) begin
            if (k_q == K_LAST) begin
              state_d = ST_LOAD;
              a_cnt_d = '0;
              b_cnt_d = '0;
              k_d     = '0;
            end else begin
              k_d = k_q + IDX_BITS'(1);
            end
          end
        end
        default: state_d = ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_mm_operand_feeder.sv
// Randomized and directed bench for mm_operand_feeder against a matrix-level
// reference model; includes a small N=1 instance.
module tb_mm_operand_feeder;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned RW = N * DW;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, load_valid, load_is_b, load_ready;
  logic [DW-1:0] load_row [N-1:0];
  logic          a_v, b_v, last, input_ready, busy;
  logic [DW-1:0] a_data [N-1:0];
  logic [DW-1:0] b_data [N-1:0];

  mm_operand_feeder #(.DATA_WIDTH(DW), .N(N)) dut (
    .clk(clk), .reset(reset),
    .load_valid_i(load_valid), .load_is_b_i(load_is_b), .load_row_i(load_row),
    .load_ready_o(load_ready), .a_input_valid_o(a_v), .b_input_valid_o(b_v),
    .a_data_o(a_data), .b_data_o(b_data), .last_o(last),
    .input_ready_i(input_ready), .busy_o(busy)
  );

  logic          reset1, lv1, isb1, rdy1, av1, bv1, last1, ir1, busy1;
  logic [DW-1:0] row1 [0:0];
  logic [DW-1:0] ad1 [0:0];
  logic [DW-1:0] bd1 [0:0];

  mm_operand_feeder #(.DATA_WIDTH(DW), .N(1)) dut1 (
    .clk(clk), .reset(reset1),
    .load_valid_i(lv1), .load_is_b_i(isb1), .load_row_i(row1),
    .load_ready_o(rdy1), .a_input_valid_o(av1), .b_input_valid_o(bv1),
    .a_data_o(ad1), .b_data_o(bd1), .last_o(last1),
    .input_ready_i(ir1), .busy_o(busy1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: matrices plus row counts and the number of transfers made
  logic [DW-1:0] ma [N][N];
  logic [DW-1:0] mb [N][N];
  bit strm;
  int na, nb, kk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic cyc(input bit rst, input bit lv, input bit isb,
                     input logic [RW-1:0] rowp, input bit ir);
    logic [RW-1:0] ea, eb, ga, gb;
    bit erdy;
    @(negedge clk);
    reset = rst; load_valid = lv; load_is_b = isb; input_ready = ir;
    for (int i = 0; i < N; i++) load_row[i] = rowp[i*DW +: DW];
    #1;
    ea = '0; eb = '0;
    erdy = 1'b0;
    if (!rst && !strm) erdy = isb ? (nb < N) : (na < N);
    if (!rst && strm)
      for (int i = 0; i < N; i++) begin
        ea[i*DW +: DW] = ma[i][kk];
        eb[i*DW +: DW] = mb[kk][i];
      end
    for (int i = 0; i < N; i++) begin
      ga[i*DW +: DW] = a_data[i];
      gb[i*DW +: DW] = b_data[i];
    end
    check_eq("load_ready", 64'(load_ready), 64'(erdy));
    check_eq("valid_ab", 64'({a_v, b_v}), (!rst && strm) ? 64'd3 : 64'd0);
    check_eq("busy", 64'(busy), 64'(!rst && strm));
    check_eq("last", 64'(last), 64'(!rst && strm && kk == N - 1));
    check_eq("a_data", 64'(ga), 64'(ea));
    check_eq("b_data", 64'(gb), 64'(eb));
    @(posedge clk);
    if (rst) begin
      strm = 0; na = 0; nb = 0; kk = 0;
    end else if (!strm) begin
      if (lv && erdy) begin
        for (int j = 0; j < N; j++) begin
          if (isb) mb[nb][j] = rowp[j*DW +: DW];
          else     ma[na][j] = rowp[j*DW +: DW];
        end
        if (isb) nb++; else na++;
        if (na == N && nb == N) strm = 1;
      end
    end else if (ir) begin
      if (kk == N - 1) begin
        strm = 0; na = 0; nb = 0; kk = 0;
      end else kk++;
    end
  endtask

  function automatic logic [RW-1:0] splat(input logic [DW-1:0] v);
    logic [RW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v;
    return r;
  endfunction

  task automatic drain(input bit ir_rand);
    int guard = 0;
    while (strm && guard < 200) begin
      cyc(0, 0, 0, '0, ir_rand ? ($urandom % 3 != 0) : 1'b1);
      guard++;
    end
    if (strm) check_eq("drain_timeout", 64'd1, 64'd0);
  endtask

  initial begin
    logic [RW-1:0] r;
    bit pat [7];
    strm = 0; na = 0; nb = 0; kk = 0;
    reset1 = 1'b1; lv1 = 1'b0; isb1 = 1'b0; ir1 = 1'b1; row1[0] = '0;

    cyc(1, 0, 0, '0, 1);
    cyc(1, 1, 0, '1, 1);

    // A = 1..16 row-major, B = identity, ready always high
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) r[j*DW +: DW] = DW'(i * N + j + 1);
      cyc(0, 1, 0, r, 1);
    end
    for (int i = 0; i < N; i++) begin
      r = '0;
      r[i*DW +: DW] = 8'd1;
      cyc(0, 1, 1, r, 1);
    end
    drain(0);
    cyc(0, 0, 0, '0, 1);

    // Interleaved load with two surplus A rows that must stall
    for (int i = 0; i < N; i++) begin
      cyc(0, 1, 0, RW'({$urandom, $urandom}), 1);
      if (i < N - 1) cyc(0, 1, 1, RW'({$urandom, $urandom}), 1);
    end
    cyc(0, 1, 0, RW'({$urandom, $urandom}), 1);
    cyc(0, 1, 0, RW'({$urandom, $urandom}), 1);
    cyc(0, 1, 1, RW'({$urandom, $urandom}), 1);

    // Stream under ready pattern 1,0,0,1,1,0,1
    pat = '{1, 0, 0, 1, 1, 0, 1};
    for (int p = 0; p < 7; p++) cyc(0, 0, 0, '0, pat[p]);
    drain(0);

    // Reset during k=2, then reload all-7 / all-2
    for (int i = 0; i < 2 * N; i++) cyc(0, 1, i[0], RW'({$urandom, $urandom}), 1);
    while (strm && kk < 2) cyc(0, 0, 0, '0, 1);
    cyc(1, 0, 0, '0, 1);
    cyc(0, 0, 0, '0, 1);
    for (int i = 0; i < N; i++) cyc(0, 1, 0, splat(8'd7), 1);
    for (int i = 0; i < N; i++) cyc(0, 1, 1, splat(8'd2), 1);
    drain(0);

    // Random traffic with occasional resets
    for (int c = 0; c < 600; c++)
      cyc(($urandom % 80) == 0, ($urandom % 4) != 0, $urandom % 2,
          RW'({$urandom, $urandom}), ($urandom % 3) != 0);
    drain(1);

    // N = 1 instance: A=[3], B=[5]
    @(negedge clk); reset1 = 1'b1; #1;
    check_eq("n1_reset_valid", 64'({av1, bv1, busy1, rdy1}), 64'd0);
    @(negedge clk); reset1 = 1'b0; lv1 = 1'b1; isb1 = 1'b0; row1[0] = 8'd3; #1;
    check_eq("n1_ready_a", 64'(rdy1), 64'd1);
    @(negedge clk); isb1 = 1'b1; row1[0] = 8'd5; #1;
    check_eq("n1_ready_b", 64'(rdy1), 64'd1);
    @(negedge clk); lv1 = 1'b0; #1;
    check_eq("n1_valid", 64'({av1, bv1, busy1}), 64'd7);
    check_eq("n1_a_data", 64'(ad1[0]), 64'd3);
    check_eq("n1_b_data", 64'(bd1[0]), 64'd5);
    check_eq("n1_last", 64'(last1), 64'd1);
    @(negedge clk); #1;
    check_eq("n1_done_valid", 64'({av1, busy1, last1}), 64'd0);
    check_eq("n1_reload_ready", 64'(rdy1), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
